// File: rtl/fd_skid_stage.sv
// fd_skid_stage: fetch/decode pipeline stage with valid/ready handshakes,
// a one-entry skid buffer, synchronous flush, NOP bubbles on the output,
// and saturating stall/flush counters for performance debug.
module fd_skid_stage #(
  parameter int                  INSTR_W   = 20,
  parameter int                  PC_W      = 16,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
  parameter int                  CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  // State encoding is {main_valid, skid_valid}; the skid is only ever full
  // while the main entry is full, so 2'b01 is unreachable.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_TWO   = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;

  assign main_valid = (state_q != S_EMPTY);
  assign skid_valid = (state_q == S_TWO);

  // in_ready uses only registered skid state plus flush/reset, so out_ready
  // never reaches it combinationally.
  assign in_ready = ~skid_valid & ~flush & ~reset;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  assign out_valid = main_valid;
  assign out_pc    = main_pc_q;
  assign out_instr = main_valid ? main_instr_q : NOP_INSTR;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Next-state and datapath: reset beats flush, flush beats any handshake.
  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (reset) begin
      state_d      = S_EMPTY;
      main_pc_d    = '0;
      main_instr_d = NOP_INSTR;
      skid_pc_d    = '0;
      skid_instr_d = NOP_INSTR;
    end else if (flush) begin
      // Keep the redirect PC visible on out_pc while the stage is empty.
      state_d   = S_EMPTY;
      main_pc_d = in_pc;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d      = S_ONE;
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end else if (in_fire) begin
            state_d      = S_TWO;
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
          end
        end
        S_TWO: begin
          // Skid is older than anything fetch offers next, so it moves up.
          if (out_fire) begin
            state_d      = S_ONE;
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Saturating performance counters; flush cycles are not stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (flush) begin
        if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else if (main_valid && !out_ready) begin
        if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
    end
  end

  // State register; reset is folded into the _d logic above.
  always_ff @(posedge clk) begin
    state_q      <= state_d;
    main_pc_q    <= main_pc_d;
    main_instr_q <= main_instr_d;
    skid_pc_q    <= skid_pc_d;
    skid_instr_q <= skid_instr_d;
    stall_cnt_q  <= stall_cnt_d;
    flush_cnt_q  <= flush_cnt_d;
  end

endmodule
